// File: rtl/li_encoder.sv
// ---------------------------------------------------------------------------
// li_encoder: turns (rd, 32-bit constant) into the minimal RV32I ADDI / LUI /
// LUI+ADDI sequence with valid/ready on both sides.      Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module li_encoder #(
  parameter int WORD_SIZE    = 32,
  parameter bit SKIP_ZERO_RD = 1'b0,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic [4:0]             ReqRd,
  input  logic [WORD_SIZE-1:0]   ReqImm,
  output logic                   InstrValid,
  input  logic                   InstrReady,
  output logic [WORD_SIZE-1:0]   Instr,
  output logic                   InstrLast,
  output logic [COUNT_WIDTH-1:0] InstrCount
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_EMIT_LUI  = 2'd1;
  localparam logic [1:0] S_EMIT_ADDI = 2'd2;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic [1:0]             state_q, state_d;
  logic [WORD_SIZE-1:0]   instr_q, instr_d;
  logic [WORD_SIZE-1:0]   addi_q, addi_d;
  logic                   last_q, last_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [11:0] lo;
  logic [19:0] hi;
  logic        fits_12;
  logic        out_hs;

  assign lo      = ReqImm[11:0];
  assign fits_12 = (ReqImm == {{(WORD_SIZE-12){lo[11]}}, lo});
  // Upper part pre-compensates for the sign-extended ADDI that follows.
  assign hi      = ReqImm[31:12] + {19'd0, ReqImm[11]};
  assign out_hs  = (state_q != S_IDLE) && InstrReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      addi_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addi_q  <= addi_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addi_d  = addi_q;
    last_d  = last_q;
    count_d = count_q;
    if (out_hs && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          if (ReqRd == 5'd0) begin
            if (SKIP_ZERO_RD == 1'b0) begin
              state_d = S_EMIT_ADDI;
              instr_d = {20'd0, 5'd0, OP_ADDI};
              last_d  = 1'b1;
            end
          end else if (fits_12) begin
            state_d = S_EMIT_ADDI;
            instr_d = {lo, 5'd0, 3'b000, ReqRd, OP_ADDI};
            last_d  = 1'b1;
          end else if (lo == 12'd0) begin
            state_d = S_EMIT_LUI;
            instr_d = {ReqImm[31:12], ReqRd, OP_LUI};
            last_d  = 1'b1;
          end else begin
            state_d = S_EMIT_LUI;
            instr_d = {hi, ReqRd, OP_LUI};
            addi_d  = {lo, ReqRd, 3'b000, ReqRd, OP_ADDI};
            last_d  = 1'b0;
          end
        end
      end
      S_EMIT_LUI: begin
        if (out_hs) begin
          if (last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_EMIT_ADDI;
            instr_d = addi_q;
            last_d  = 1'b1;
          end
        end
      end
      S_EMIT_ADDI: begin
        if (out_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ReqReady   = (state_q == S_IDLE);
    InstrValid = (state_q != S_IDLE);
    Instr      = instr_q;
    InstrLast  = last_q;
    InstrCount = count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_li_encoder.sv
// ---------------------------------------------------------------------------
// tb_li_encoder: scoreboard bench for li_encoder.         Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_li_encoder;

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid, ReqReady, InstrValid, InstrReady, InstrLast;
  logic [4:0]  ReqRd;
  logic [31:0] ReqImm, Instr;
  logic [15:0] InstrCount;

  logic        s_valid, s_rready, s_ivalid, s_iready, s_last;
  logic [4:0]  s_rd;
  logic [31:0] s_imm, s_instr;
  logic [1:0]  s_count;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt = 0;
  int   base = 0;

  always #5 clk = ~clk;

  li_encoder #(.WORD_SIZE(32), .SKIP_ZERO_RD(1'b0), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqRd(ReqRd), .ReqImm(ReqImm),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .InstrLast(InstrLast), .InstrCount(InstrCount)
  );

  li_encoder #(.WORD_SIZE(32), .SKIP_ZERO_RD(1'b1), .COUNT_WIDTH(2)) dut_skip (
    .clk(clk), .reset(reset),
    .ReqValid(s_valid), .ReqReady(s_rready), .ReqRd(s_rd), .ReqImm(s_imm),
    .InstrValid(s_ivalid), .InstrReady(s_iready), .Instr(s_instr),
    .InstrLast(s_last), .InstrCount(s_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && InstrValid && InstrReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instr", Instr, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr", Instr, e.instr);
        chk("last", {31'd0, InstrLast}, {31'd0, e.last});
      end
      hs_cnt++;
    end
  end

  task automatic push(input logic [31:0] instr, input logic last);
    exp_t e;
    e.instr = instr;
    e.last  = last;
    exp_q.push_back(e);
  endtask

  // Issue one request; checks that output appears one cycle after acceptance.
  task automatic send(input logic [4:0] rd, input logic [31:0] imm, input bit expect_out);
    bit acc = 0;
    @(posedge clk); #1;
    ReqValid = 1'b1; ReqRd = rd; ReqImm = imm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ReqReady) begin
        @(posedge clk); #1;
        ReqValid = 1'b0; ReqRd = 5'd31; ReqImm = 32'hDEADBEEF;
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      ReqValid = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk("latency1_valid", {31'd0, InstrValid}, {31'd0, expect_out});
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !InstrValid && ReqReady) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    chk("count", {16'd0, InstrCount}, 32'(hs_cnt - base));
  endtask

  initial begin
    reset = 1'b1; ReqValid = 1'b0; ReqRd = '0; ReqImm = '0; InstrReady = 1'b1;
    s_valid = 1'b0; s_rd = '0; s_imm = '0; s_iready = 1'b1;
    #12;
    chk("rst_ReqReady", {31'd0, ReqReady}, 32'd1);
    chk("rst_InstrValid", {31'd0, InstrValid}, 32'd0);
    chk("rst_Instr", Instr, 32'd0);
    chk("rst_InstrLast", {31'd0, InstrLast}, 32'd0);
    chk("rst_InstrCount", {16'd0, InstrCount}, 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    push(32'h06400293, 1'b1);
    send(5'd5, 32'd100, 1);
    wait_idle();
    chk("count_first", {16'd0, InstrCount}, 32'd1);

    push(32'h12345537, 1'b1);
    send(5'd10, 32'h12345000, 1);
    wait_idle();

    push(32'h123460B7, 1'b0);
    push(32'hFFF08093, 1'b1);
    send(5'd1, 32'h12345FFF, 1);
    @(negedge clk);
    chk("no_bubble_addi", {31'd0, InstrValid}, 32'd1);
    wait_idle();

    push(32'h80000113, 1'b1);
    send(5'd2, 32'hFFFFF800, 1);
    wait_idle();

    push(32'h800001B7, 1'b0);
    push(32'hFFF18193, 1'b1);
    send(5'd3, 32'h7FFFFFFF, 1);
    wait_idle();

    push(32'h00000013, 1'b1);
    send(5'd0, 32'h00001234, 1);
    wait_idle();

    push(32'hFFF00393, 1'b1);
    send(5'd7, 32'hFFFFFFFF, 1);
    wait_idle();

    // Backpressure on the LUI with a competing request held on the input.
    InstrReady = 1'b0;
    push(32'h123460B7, 1'b0);
    push(32'hFFF08093, 1'b1);
    send(5'd1, 32'h12345FFF, 1);
    ReqValid = 1'b1; ReqRd = 5'd9; ReqImm = 32'h00000005;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_instr", Instr, 32'h123460B7);
      chk("bp_valid_last", {30'd0, InstrValid, InstrLast}, 32'd2);
      chk("bp_reqready", {31'd0, ReqReady}, 32'd0);
    end
    @(posedge clk); #1;
    ReqValid = 1'b0; InstrReady = 1'b1;
    wait_idle();

    // Asynchronous reset while the second instruction is pending.
    InstrReady = 1'b0;
    push(32'h123460B7, 1'b0);
    push(32'hFFF08093, 1'b1);
    send(5'd1, 32'h12345FFF, 1);
    @(posedge clk); #1 InstrReady = 1'b1;
    @(posedge clk); #1 InstrReady = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_InstrValid", {31'd0, InstrValid}, 32'd0);
    chk("arst_ReqReady", {31'd0, ReqReady}, 32'd1);
    chk("arst_InstrCount", {16'd0, InstrCount}, 32'd0);
    exp_q.delete();
    base = hs_cnt;
    @(negedge clk); #2 reset = 1'b0;
    InstrReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_addi", {31'd0, InstrValid}, 32'd0);
    end

    // Skipping instance: rd==0 is swallowed, 2-bit counter saturates.
    @(posedge clk); #1;
    s_valid = 1'b1; s_rd = 5'd0; s_imm = 32'h00000077;
    @(posedge clk); #1 s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("skip_rd0_idle", {30'd0, s_rready, s_ivalid}, 32'd2);
    end
    chk("skip_rd0_count", {30'd0, s_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_rd = 5'd4; s_imm = 32'(i);
      @(posedge clk); #1 s_valid = 1'b0;
      @(negedge clk);
      chk("skip_addi", s_instr, 32'h00000213 | (32'(i) << 20));
      chk("skip_addi_valid", {31'd0, s_ivalid}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("sat_count", {30'd0, s_count}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/li_encoder.md
Name: li_encoder

Overview:
- Encoder for load-immediate. It is the inverse of the core's immediate extraction path.
- Accepts a destination register and a 32-bit constant. Emits the minimal RV32I sequence that materialises the constant: ADDI alone, LUI alone, or LUI then ADDI.
- Sits between the test/boot program generator and instruction memory fill logic. Valid/ready handshakes on both sides.

Parameters:
- WORD_SIZE, 32, instruction and constant width; only 32 is supported.
- SKIP_ZERO_RD, 0, if 1 a request with rd==0 is consumed and emits nothing; if 0 it emits the canonical NOP.
- COUNT_WIDTH, 16, width of the emitted-instruction counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  block can accept a request.
- ReqRd  input  5  destination register.
- ReqImm  input  WORD_SIZE  constant to load.
- InstrValid  output  1  Instr holds a valid encoded instruction.
- InstrReady  input  1  consumer accepts Instr.
- Instr  output  WORD_SIZE  encoded instruction.
- InstrLast  output  1  Instr is the final instruction of the current request.
- InstrCount  output  COUNT_WIDTH  saturating count of instructions handed off.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - ReqReady=1, InstrValid=0, Instr=0, InstrLast=0, InstrCount=0.
  - Takes effect immediately, including mid-sequence; any pending second instruction is discarded.
- FSM states: IDLE, EMIT_LUI, EMIT_ADDI.
  - ReqReady is 1 only in IDLE. A request is accepted when ReqValid&&ReqReady at a clk edge.
  - ReqRd and ReqImm are latched on acceptance. Later input changes are ignored.
- Classification on acceptance (lo = ReqImm[11:0], sext(lo) = lo sign-extended to 32 bits):
  - rd==0 with SKIP_ZERO_RD=1: stay in IDLE, emit nothing.
  - rd==0 with SKIP_ZERO_RD=0: go to EMIT_ADDI with ADDI x0,x0,0 (0x00000013), InstrLast=1.
  - ReqImm==sext(lo) (range -2048..2047): go to EMIT_ADDI with ADDI rd,x0,lo, InstrLast=1.
  - lo==0: go to EMIT_LUI with LUI rd,ReqImm[31:12], InstrLast=1.
  - Otherwise: go to EMIT_LUI with LUI rd,hi, InstrLast=0, where hi=((ReqImm+32'h800) mod 2^32)[31:12].
    - The add wraps at 32 bits, e.g. 0x7FFFFFFF gives hi=0x80000.
    - After the LUI handshake, go to EMIT_ADDI with ADDI rd,rd,lo, InstrLast=1.
- Encodings:
  - ADDI = {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011}.
  - LUI = {imm[31:12], rd[4:0], 7'b0110111}.
- Output timing:
  - Instr, InstrValid and InstrLast are registered. They become valid the cycle after acceptance (latency 1).
  - While InstrValid=1 and InstrReady=0, Instr and InstrLast hold stable. InstrValid stays 1 (no drop, no change).
  - Handshake occurs when InstrValid&&InstrReady at an edge. The next Instr, if any, appears the following cycle with no bubble.
  - On the last handshake, return to IDLE: InstrValid=0 and ReqReady=1 the next cycle.
  - Back-to-back requests: at most one instruction per cycle; at least one IDLE cycle between requests.
- InstrCount:
  - Increments by 1 on each output handshake.
  - Saturates at all-ones with no wrap.
  - Skipped rd==0 requests do not count.

Test Plan:
- Small positive: ReqRd=5, ReqImm=100 -> one cycle later Instr=0x06400293, InstrLast=1; after handshake ReqReady=1, InstrCount=1.
- LUI only: ReqRd=10, ReqImm=0x12345000 -> Instr=0x12345537, InstrLast=1; no ADDI follows.
- Split with rounding: ReqRd=1, ReqImm=0x12345FFF -> 0x123460B7 (InstrLast=0), then 0xFFF08093 (InstrLast=1) on consecutive cycles with InstrReady=1.
- Boundaries:
  - ReqRd=2, ReqImm=0xFFFFF800 -> single 0x80000113.
  - ReqRd=3, ReqImm=0x7FFFFFFF -> 0x800001B7 then 0xFFF18193.
- Backpressure/rd0:
  - Hold InstrReady=0 for 5 cycles during the split case -> Instr stays 0x123460B7, ReqValid ignored.
  - ReqRd=0 -> 0x00000013 when SKIP_ZERO_RD=0; nothing, with ReqReady staying 1, when SKIP_ZERO_RD=1.
- Reset mid-sequence: assert reset asynchronously between LUI and ADDI -> outputs immediately InstrValid=0, ReqReady=1, InstrCount=0; no ADDI emitted after release.
